fmv_pixel_pacer: RTL and testbench

- Consumer end of the FMV pixel-clock strobe: buffers decoded MPEG pixels arriving from the FMV decoder in bursts.
- Releases exactly one pixel per `newpixel` strobe from the sample rate converter, so output runs at 15 MHz (Green Book) or about 13.5 MHz (VCD) equivalent.
- Applies per-line horizontal crop and width.
- Pads short or starved lines with black and flags underflow to the display path.

---
 rtl/fmv_pixel_pacer.sv | 165 ++++++++++++++++
 tb/tb_fmv_pixel_pacer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmv_pixel_pacer.sv
// FMV pixel pacer: buffers decoder pixel bursts in a small FIFO and releases
// one pixel per sample-rate-converter strobe, applying per-line crop/width,
// black padding for short or starved lines, and a sticky underflow flag.
module fmv_pixel_pacer #(
  parameter int DEPTH   = 16,
  parameter int PIXEL_W = 24
) (
  input  logic               clk30,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_sol,
  input  logic               newpixel,
  input  logic               line_start,
  input  logic [9:0]         crop_left,
  input  logic [9:0]         out_width,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_valid,
  output logic               out_line_done,
  output logic               underflow,
  input  logic               clear_underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, SKIP, EMIT} state_t;

  // FIFO entries are {sol, pixel}; pointers carry one extra wrap bit
  logic [PIXEL_W:0]   mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               empty, full, push, pop;
  logic [PIXEL_W:0]   head;
  logic               head_sol;
  logic [PIXEL_W-1:0] head_pix;

  state_t     state, state_d;
  logic [9:0] skip_cnt, skip_d, emit_cnt, emit_d;
  // set once the first pixel of the current line has left the FIFO; any
  // sol seen after that belongs to the next line
  logic       took_first, first_d;
  logic       fire, black, set_uf, done_d;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_sol = head[PIXEL_W];
  assign head_pix = head[PIXEL_W-1:0];

  // FIFO storage write (no reset needed; validity comes from the pointers)
  always_ff @(posedge clk30) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_sol, in_pixel};
  end

  // FIFO pointers; pop is only ever raised when the FIFO was non-empty
  always_ff @(posedge clk30) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // line state register and per-line counters
  always_ff @(posedge clk30) begin
    if (reset) begin
      state      <= IDLE;
      skip_cnt   <= '0;
      emit_cnt   <= '0;
      took_first <= 1'b0;
    end else begin
      state      <= state_d;
      skip_cnt   <= skip_d;
      emit_cnt   <= emit_d;
      took_first <= first_d;
    end
  end

  // next-state, pop and emission decisions
  always_comb begin
    state_d = state;
    skip_d  = skip_cnt;
    emit_d  = emit_cnt;
    first_d = took_first;
    pop     = 1'b0;
    fire    = 1'b0;
    black   = 1'b0;
    set_uf  = 1'b0;
    done_d  = 1'b0;
    if (line_start) begin
      // start (or abort and restart) a line with freshly latched geometry
      skip_d  = crop_left;
      emit_d  = out_width;
      first_d = 1'b0;
      if (out_width == 10'd0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = SYNC;
      end
    end else begin
      case (state)
        SYNC: begin
          if (!empty) begin
            if (head_sol) state_d = SKIP;
            else          pop     = 1'b1;
          end
        end
        SKIP: begin
          if (skip_cnt == 10'd0) begin
            state_d = EMIT;
          end else if (!empty) begin
            if (head_sol && took_first) begin
              state_d = EMIT;
            end else begin
              pop     = 1'b1;
              skip_d  = skip_cnt - 10'd1;
              first_d = 1'b1;
            end
          end
        end
        EMIT: begin
          if (newpixel) begin
            fire = 1'b1;
            if (!empty && !(head_sol && took_first)) begin
              pop     = 1'b1;
              first_d = 1'b1;
            end else begin
              black  = 1'b1;
              set_uf = empty;
            end
            emit_d = emit_cnt - 10'd1;
            if (emit_cnt <= 10'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // registered output stage and sticky underflow (set beats clear)
  always_ff @(posedge clk30) begin
    if (reset) begin
      out_pixel     <= '0;
      out_valid     <= 1'b0;
      out_line_done <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      out_valid     <= fire;
      out_line_done <= done_d;
      if (fire) out_pixel <= black ? '0 : head_pix;
      if (set_uf)               underflow <= 1'b1;
      else if (clear_underflow) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fmv_pixel_pacer.sv
// Scoreboard bench for fmv_pixel_pacer: expected emissions are queued as
// strobes are planned and compared when out_valid/out_line_done appear.
module tb_fmv_pixel_pacer;
  localparam int DEPTH = 16;
  localparam int PW    = 24;

  logic          clk30 = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, in_sol = 1'b0, newpixel = 1'b0;
  logic          line_start = 1'b0, clear_underflow = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic [9:0]    crop_left = '0, out_width = '0;
  logic          in_ready, out_valid, out_line_done, underflow;
  logic [PW-1:0] out_pixel;

  int total = 0, bad = 0;

  typedef struct {logic v; logic d; logic [PW-1:0] p;} exp_t;
  exp_t sb[$];
  exp_t e;

  fmv_pixel_pacer #(.DEPTH(DEPTH), .PIXEL_W(PW)) dut (
    .clk30(clk30), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sol(in_sol), .newpixel(newpixel),
    .line_start(line_start), .crop_left(crop_left), .out_width(out_width),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_line_done(out_line_done),
    .underflow(underflow), .clear_underflow(clear_underflow)
  );

  always #5 clk30 = ~clk30;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard consumer, sampled away from the active edge
  always @(negedge clk30) begin
    if (!reset && (out_valid || out_line_done)) begin
      if (sb.size() == 0) chk("unexp_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("o_valid", {31'd0, out_valid}, {31'd0, e.v});
        chk("o_done", {31'd0, out_line_done}, {31'd0, e.d});
        if (e.v) chk("o_pix", {8'd0, out_pixel}, {8'd0, e.p});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk30);
    #1;
  endtask

  task automatic push(input logic [PW-1:0] p, input logic s);
    int n = 0;
    in_valid = 1'b1; in_pixel = p; in_sol = s;
    while (!in_ready && n < 50) begin cyc(1); n++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    cyc(1);
    in_valid = 1'b0; in_sol = 1'b0;
  endtask

  task automatic ls(input logic [9:0] c, input logic [9:0] w);
    crop_left = c; out_width = w; line_start = 1'b1;
    cyc(1);
    line_start = 1'b0;
  endtask

  task automatic expect_px(input logic [PW-1:0] p, input logic d);
    exp_t x;
    x.v = 1'b1; x.d = d; x.p = p;
    sb.push_back(x);
  endtask

  // strobe and check one-clock latency; optionally check in_ready after pop
  task automatic strobe(input bit ck_ready);
    newpixel = 1'b1;
    cyc(1);
    newpixel = 1'b0;
    chk("latency", {31'd0, out_valid}, 1);
    if (ck_ready) chk("ready_after_pop", {31'd0, in_ready}, 1);
    cyc(1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin cyc(1); n++; end
    if (sb.size() != 0) chk("sb_timeout", sb.size(), 0);
  endtask

  initial begin
    int cnt;
    exp_t z;
    cyc(3);
    reset = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_done", {31'd0, out_line_done}, 0);
    chk("rst_uf", {31'd0, underflow}, 0);
    chk("rst_pix", {8'd0, out_pixel}, 0);

    // basic line: crop 1, width 4
    for (int i = 1; i <= 8; i++) push(PW'(i), i == 1);
    ls(10'd1, 10'd4);
    cyc(10);
    for (int i = 2; i <= 5; i++) expect_px(PW'(i), i == 5);
    for (int i = 0; i < 4; i++) strobe(0);
    drain();
    chk("basic_uf", {31'd0, underflow}, 0);

    // starvation (leftovers 6,7,8 resynced away first)
    push(24'h11, 1'b1); push(24'h12, 1'b0);
    ls(10'd0, 10'd4);
    cyc(10);
    expect_px(24'h11, 0); expect_px(24'h12, 0);
    expect_px(24'h0, 0);  expect_px(24'h0, 1);
    strobe(0); strobe(0);
    chk("starve_uf_pre", {31'd0, underflow}, 0);
    strobe(0);
    chk("starve_uf_set", {31'd0, underflow}, 1);
    strobe(0);
    drain();
    clear_underflow = 1'b1; cyc(1); clear_underflow = 1'b0;
    chk("uf_clear", {31'd0, underflow}, 0);

    // short line A (3 px) followed by line B (5 px)
    for (int i = 1; i <= 3; i++) push(PW'(24'h20 + i), i == 1);
    for (int i = 1; i <= 5; i++) push(PW'(24'h30 + i), i == 1);
    ls(10'd0, 10'd5);
    cyc(10);
    for (int i = 1; i <= 3; i++) expect_px(PW'(24'h20 + i), 0);
    expect_px(24'h0, 0); expect_px(24'h0, 1);
    for (int i = 0; i < 5; i++) strobe(0);
    drain();
    chk("short_uf", {31'd0, underflow}, 0);
    ls(10'd0, 10'd5);
    cyc(10);
    for (int i = 1; i <= 5; i++) expect_px(PW'(24'h30 + i), i == 5);
    for (int i = 0; i < 5; i++) strobe(0);
    drain();
    chk("lineb_uf", {31'd0, underflow}, 0);

    // back-pressure: count accepted pushes until full
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_pixel = PW'(24'h40 + cnt); in_sol = (cnt == 0);
      cyc(1);
      cnt++;
      if (!in_ready) break;
    end
    chk("bp_count", cnt, DEPTH);
    in_pixel = 24'hEE; in_sol = 1'b1;
    cyc(1);
    chk("bp_full0", {31'd0, in_ready}, 0);
    cyc(1);
    chk("bp_full1", {31'd0, in_ready}, 0);
    in_valid = 1'b0; in_sol = 1'b0;
    ls(10'd0, 10'd16);
    cyc(10);
    for (int i = 0; i < 16; i++) expect_px(PW'(24'h40 + i), i == 15);
    strobe(1);
    for (int i = 1; i < 16; i++) strobe(0);
    drain();

    // resync over garbage, then abort mid-line
    for (int i = 1; i <= 3; i++) push(PW'(24'h50 + i), 1'b0);
    for (int i = 1; i <= 4; i++) push(PW'(24'h60 + i), i == 1);
    for (int i = 1; i <= 4; i++) push(PW'(24'h70 + i), i == 1);
    ls(10'd0, 10'd4);
    cyc(12);
    expect_px(24'h61, 0); expect_px(24'h62, 0);
    strobe(0); strobe(0);
    drain();
    ls(10'd0, 10'd4);
    cyc(10);
    for (int i = 1; i <= 4; i++) expect_px(PW'(24'h70 + i), i == 4);
    for (int i = 0; i < 4; i++) strobe(0);
    drain();

    // zero-width line
    z.v = 1'b0; z.d = 1'b1; z.p = '0;
    sb.push_back(z);
    ls(10'd5, 10'd0);
    chk("w0_done", {31'd0, out_line_done}, 1);
    chk("w0_valid", {31'd0, out_valid}, 0);
    cyc(1);
    drain();

    // reset mid-EMIT with a pending strobe and underflow set
    push(24'h81, 1'b1); push(24'h82, 1'b0);
    ls(10'd0, 10'd4);
    cyc(10);
    expect_px(24'h81, 0); expect_px(24'h82, 0); expect_px(24'h0, 0);
    strobe(0); strobe(0); strobe(0);
    drain();
    chk("pre_rst_uf", {31'd0, underflow}, 1);
    push(24'h99, 1'b0);
    reset = 1'b1; newpixel = 1'b1;
    cyc(1);
    reset = 1'b0; newpixel = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 0);
    chk("mrst_ready", {31'd0, in_ready}, 1);
    chk("mrst_uf", {31'd0, underflow}, 0);
    chk("mrst_done", {31'd0, out_line_done}, 0);
    // flushed FIFO: the stale 0x99 must not appear
    push(24'h91, 1'b1);
    ls(10'd0, 10'd1);
    cyc(10);
    expect_px(24'h91, 1);
    strobe(0);
    drain();

    cyc(3);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule
